// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Valid/ready on both sides, optional two's-complement input, leading-zero mask and overflow flag.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  ovf_out,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q;
    logic [BIN_W-1:0]      mag_q;
    logic [4*DIGITS-1:0]   acc_q;
    logic                  ovf_q;
    logic                  neg_q;
    logic [CntW-1:0]       cnt_q;

    logic                  in_ready_q;
    logic                  busy_q;
    logic                  out_valid_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  neg_out_q;
    logic                  ovf_out_q;
    logic [DIGITS-1:0]     digit_en_q;

    logic [BIN_W-1:0]      mag_load;
    logic [4*DIGITS-1:0]   acc_add;
    logic [4*DIGITS-1:0]   acc_next;
    logic                  ovf_next;
    logic [DIGITS-1:0]     en_next;
    logic                  any_nz;

    // Most negative input maps to 2^(BIN_W-1), which still fits as an unsigned magnitude.
    assign mag_load = (SIGNED && binary_in[BIN_W-1]) ? (~binary_in + 1'b1) : binary_in;

    always_comb begin
        acc_add = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_add[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        acc_next = {acc_add[4*DIGITS-2:0], mag_q[BIN_W-1]};
        ovf_next = ovf_q | acc_add[4*DIGITS-1];

        any_nz  = 1'b0;
        en_next = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            any_nz     = any_nz | (acc_next[4*k +: 4] != 4'd0);
            en_next[k] = any_nz;
        end
        en_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            neg_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
            digit_en_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mag_q      <= mag_load;
                        neg_q      <= SIGNED && binary_in[BIN_W-1];
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CntW'(BIN_W);
                        state_q    <= StShift;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StShift: begin
                    acc_q <= acc_next;
                    mag_q <= {mag_q[BIN_W-2:0], 1'b0};
                    ovf_q <= ovf_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        bcd_q       <= acc_next;
                        ovf_out_q   <= ovf_next;
                        neg_out_q   <= neg_q && ((acc_next != '0) || ovf_next);
                        digit_en_q  <= en_next;
                    end
                end
                StDone: begin
                    // Result regs hold until the next conversion finishes.
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign neg_out   = neg_out_q;
    assign ovf_out   = ovf_out_q;
    assign digit_en  = digit_en_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: unsigned 16/5, signed 16/5 and unsigned 10/3 instances,
// table of vectors through a scoreboard queue plus backpressure and mid-conversion reset.
module tb_bin2bcd_seq;

    typedef struct {
        int          sel;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  en;
        logic        ovf;
        logic        neg;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_neg, a_ovf, a_busy;
    logic [15:0] a_bin;
    logic [19:0] a_bcd;
    logic [4:0]  a_en;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_neg, b_ovf, b_busy;
    logic [15:0] b_bin;
    logic [19:0] b_bcd;
    logic [4:0]  b_en;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_neg, c_ovf, c_busy;
    logic [9:0]  c_bin;
    logic [11:0] c_bcd;
    logic [2:0]  c_en;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .binary_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd_out(a_bcd),
        .neg_out(a_neg), .digit_en(a_en), .ovf_out(a_ovf), .busy(a_busy)
    );
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .binary_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd_out(b_bcd),
        .neg_out(b_neg), .digit_en(b_en), .ovf_out(b_ovf), .busy(b_busy)
    );
    bin2bcd_seq #(.BIN_W(10), .DIGITS(3), .SIGNED(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .binary_in(c_bin), .out_valid(c_out_valid), .out_ready(c_out_ready), .bcd_out(c_bcd),
        .neg_out(c_neg), .digit_en(c_en), .ovf_out(c_ovf), .busy(c_busy)
    );

    int          sel;
    logic        cur_rdy, cur_vld, cur_busy, cur_ovf, cur_neg;
    logic [19:0] cur_bcd;
    logic [4:0]  cur_en;

    always_comb begin
        cur_rdy  = a_in_ready;
        cur_vld  = a_out_valid;
        cur_busy = a_busy;
        cur_ovf  = a_ovf;
        cur_neg  = a_neg;
        cur_bcd  = a_bcd;
        cur_en   = a_en;
        if (sel == 1) begin
            cur_rdy  = b_in_ready;
            cur_vld  = b_out_valid;
            cur_busy = b_busy;
            cur_ovf  = b_ovf;
            cur_neg  = b_neg;
            cur_bcd  = b_bcd;
            cur_en   = b_en;
        end else if (sel == 2) begin
            cur_rdy  = c_in_ready;
            cur_vld  = c_out_valid;
            cur_busy = c_busy;
            cur_ovf  = c_ovf;
            cur_neg  = c_neg;
            cur_bcd  = {8'h00, c_bcd};
            cur_en   = {2'b00, c_en};
        end
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [15:0] b);
        a_in_valid = (s == 0) && v;
        b_in_valid = (s == 1) && v;
        c_in_valid = (s == 2) && v;
        a_bin = b;
        b_bin = b;
        c_bin = b[9:0];
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (cur_rdy) break;
            @(posedge clk);
            #1;
        end
        check("in_ready_wait", 32'(cur_rdy), 32'd1);
    endtask

    task automatic send(input vec_t v);
        sel = v.sel;
        #1;
        wait_ready();
        sb.push_back(v);
        drive(v.sel, 1'b1, v.bin);
        @(posedge clk);
        #1;
        drive(v.sel, 1'b0, v.bin);
        check("accept_busy", 32'({cur_busy, cur_rdy, cur_vld}), 32'b100);
    endtask

    task automatic collect();
        vec_t e;
        int   lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (cur_vld) begin
                lat = i;
                break;
            end
            check("shift_busy", 32'({cur_busy, cur_rdy}), 32'b10);
        end
        check("latency", 32'(lat), (sel == 2) ? 32'd10 : 32'd16);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got result %0h, expected none pending", cur_bcd);
        end else begin
            e = sb.pop_front();
            check("bcd_out", 32'(cur_bcd), 32'(e.bcd));
            check("digit_en", 32'(cur_en), 32'(e.en));
            check("ovf_out", 32'(cur_ovf), 32'(e.ovf));
            check("neg_out", 32'(cur_neg), 32'(e.neg));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        tbl[0]  = '{0, 16'd65535, 20'h65535, 5'b11111, 1'b0, 1'b0};
        tbl[1]  = '{0, 16'd0,     20'h00000, 5'b00001, 1'b0, 1'b0};
        tbl[2]  = '{0, 16'd9999,  20'h09999, 5'b01111, 1'b0, 1'b0};
        tbl[3]  = '{0, 16'd1,     20'h00001, 5'b00001, 1'b0, 1'b0};
        tbl[4]  = '{0, 16'd10000, 20'h10000, 5'b11111, 1'b0, 1'b0};
        tbl[5]  = '{0, 16'd12345, 20'h12345, 5'b11111, 1'b0, 1'b0};
        tbl[6]  = '{1, 16'h8000,  20'h32768, 5'b11111, 1'b0, 1'b1};
        tbl[7]  = '{1, 16'hFFFF,  20'h00001, 5'b00001, 1'b0, 1'b1};
        tbl[8]  = '{1, 16'h0000,  20'h00000, 5'b00001, 1'b0, 1'b0};
        tbl[9]  = '{1, 16'h7FFF,  20'h32767, 5'b11111, 1'b0, 1'b0};
        tbl[10] = '{1, 16'hFF9C,  20'h00100, 5'b00111, 1'b0, 1'b1};
        tbl[11] = '{2, 16'd1023,  20'h00023, 5'b00011, 1'b1, 1'b0};
        tbl[12] = '{2, 16'd999,   20'h00999, 5'b00111, 1'b0, 1'b0};
        tbl[13] = '{2, 16'd1000,  20'h00000, 5'b00001, 1'b1, 1'b0};
        tbl[14] = '{2, 16'd0,     20'h00000, 5'b00001, 1'b0, 1'b0};

        sel = 0;
        reset_n = 1'b0;
        drive(0, 1'b0, 16'd0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_in_ready", 32'(cur_rdy), 32'd1);
            check("rst_outputs", 32'({cur_vld, cur_busy, cur_ovf, cur_neg, cur_en}), 32'd0);
            check("rst_bcd", 32'(cur_bcd), 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            send(tbl[i]);
            collect();
        end

        // Result held under backpressure while a new request waits.
        a_out_ready = 1'b0;
        v = '{0, 16'd1234, 20'h01234, 5'b01111, 1'b0, 1'b0};
        send(v);
        collect();
        drive(0, 1'b1, 16'd42);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 32'({cur_vld, cur_rdy, cur_busy}), 32'b100);
            check("bp_bcd", 32'(cur_bcd), 32'h01234);
        end
        a_out_ready = 1'b1;
        sb.push_back('{0, 16'd42, 20'h00042, 5'b00011, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("bp_release", 32'({cur_vld, cur_rdy, cur_busy}), 32'b010);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 16'd0);
        check("bp_accept42", 32'({cur_vld, cur_rdy, cur_busy}), 32'b001);
        collect();

        // Reset in the 8th shift cycle discards the conversion.
        v = '{0, 16'd4321, 20'h04321, 5'b01111, 1'b0, 1'b0};
        send(v);
        void'(sb.pop_back());
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", 32'(cur_busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midrst_in_ready", 32'(cur_rdy), 32'd1);
        check("midrst_outputs", 32'({cur_vld, cur_busy, cur_ovf, cur_neg, cur_en}), 32'd0);
        check("midrst_bcd", 32'(cur_bcd), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", 32'({cur_vld, cur_rdy}), 32'b01);
        end
        v = '{0, 16'd17, 20'h00017, 5'b00011, 1'b0, 1'b0};
        send(v);
        collect();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
